mpsoc_spram_arbiter: RTL and testbench
======================================

# mpsoc_spram_arbiter

Two-requester arbiter that shares one single-port synchronous RAM (16-bit words, byte write enables, active-low chip/write enables, one-cycle read latency) between a CPU data port (master 0) and a DMA port (master 1). It sits between both masters and the `mpsoc_spram_synthesis` RAM instance. It grants one access per cycle using round-robin with a bounded burst hold, and routes registered read data back to the owning master.

## Interface
Parameters:
- `AW`, 6, RAM word address width.
- `DW`, 16, data width; byte enables fixed at 2 (`DW/8`).
- `MAX_BURST`, 4, maximum consecutive grants to one master while the other waits; legal range 1..15.

Ports (clock `mclk`, single domain; reset `puc_rst` asynchronous, active-high):
- `mclk` in 1: clock; also drives the RAM clock.
- `puc_rst` in 1: asynchronous active-high reset.
- `m0_req` / `m1_req` in 1: access request, held until granted.
- `m0_addr` / `m1_addr` in AW: word address.
- `m0_din` / `m1_din` in DW: write data.
- `m0_wen` / `m1_wen` in 2: byte write enable, active-high; 2'b00 means read.
- `m0_gnt` / `m1_gnt` out 1: combinational grant; access is performed in this cycle.
- `m0_dout` / `m1_dout` out DW: read data; 0 when the matching rvalid is low.
- `m0_rvalid` / `m1_rvalid` out 1: read data valid, one cycle after the read grant.
- `ram_addr` out AW, `ram_din` out DW, `ram_cen` out 1 (low active), `ram_wen` out 2 (low active): RAM side.
- `ram_dout` in DW: RAM read data.

## Operation
- State registers:
  - `owner` (last granted master), reset 1, so master 0 wins the first contention.
  - `cnt`, width $clog2(MAX_BURST+1), reset 0.
  - `rd_pend`, reset 0.
  - `rd_tag`, reset 0.
- Arbiter states: IDLE (`cnt`==0) and HOLD (`cnt`>0). `hold` = HOLD and `cnt` < MAX_BURST.
- Grant rules, per cycle:
  - No requests: no grant; `cnt` goes to 0; `owner` is unchanged.
  - One request: grant that master.
  - Both request: grant `owner` if `hold`, else grant `~owner`.
  - After IDLE, contention therefore goes to the master not served most recently.
- Update on a grant to master g:
  - If g == `owner` and state is HOLD: `cnt` <= min(`cnt`+1, MAX_BURST). This saturates, so a lone requester keeps the grant indefinitely.
  - Otherwise: `owner` <= g and `cnt` <= 1.
- RAM drive:
  - Granted: `ram_cen`=0, `ram_addr`/`ram_din` from the granted master, `ram_wen` = ~`mg_wen`.
  - Not granted: `ram_cen`=1, `ram_wen`=2'b11, `ram_addr`=0, `ram_din`=0.
- Read return:
  - On a granted read, `rd_pend` <= 1 and `rd_tag` <= g. Otherwise `rd_pend` <= 0.
  - `mX_rvalid` = `rd_pend` & (`rd_tag`==X).
  - `mX_dout` = `mX_rvalid` ? `ram_dout` : 0.
- Writes produce no rvalid. Partial writes with `wen` 2'b01 or 2'b10 pass through unchanged.
- Reset asserted mid-operation: a pending read is dropped (rvalid 0 next edge), the arbiter returns to IDLE with `owner`=1, and grants are suppressed while reset is high.

## Timing
- Reset values: all gnt 0, all rvalid 0, all dout 0, `ram_cen`=1, `ram_wen`=2'b11, `ram_addr`=0, `ram_din`=0.
- Grant is combinational from req and state in the same cycle.
- The RAM samples the access at the next `mclk` edge.
- Read latency: request granted in cycle N, then `mX_rvalid` and data are valid in cycle N+1. Back-to-back reads give a one-per-cycle stream.
- A denied master keeps req and its address/data/wen stable until it is granted. Changing them while waiting is legal; the values sampled in the grant cycle are used.
- Worst-case wait for a master under continuous contention: MAX_BURST cycles.
- Combinational path: req to gnt and to the RAM-side outputs. No path from `ram_dout` to any gnt.

## Structure
- Package `mpsoc_spram_arbiter_pkg` holds:
  - typedef `master_t` (1-bit master index);
  - localparams `WEN_READ`=2'b00, `RAM_WEN_IDLE`=2'b11, `BE_W`=2.
- Sub-module `mpsoc_spram_arbiter_rr`: grant logic plus `owner`/`cnt` state, with inputs req[1:0] and outputs gnt[1:0].
- The top holds the RAM-side mux and the read-return pipe.

## Test plan
- Reset, then idle: all outputs at reset values. `m0_req`=1 read from addr 5 → `m0_gnt`=1 the same cycle, `ram_cen`=0, `ram_addr`=5; next cycle `m0_rvalid`=1 with `m0_dout` equal to the stored word.
- Both request from the first cycle, MAX_BURST=4, both held → grant sequence 0,0,0,0,1,1,1,1,0…; each master waits no more than 4 cycles.
- Write m1 `wen`=2'b10, data 16'hAB12 to addr 3 over an existing 16'h0000, then m0 reads addr 3 → `m0_dout`=16'hAB00; `m1_rvalid` never asserted.
- m1 alone requests for 10 cycles → grant held for all 10 with `cnt` saturated at 4. m0 then requests → m0 granted in the next cycle.
- Read granted to m1 in cycle N while m0 is denied → in cycle N+1, `m1_rvalid`=1, and `m0_rvalid`=0 with `m0_dout`=0.
- Assert `puc_rst` in the cycle after a read grant → rvalid stays 0, `ram_cen`=1. After release with both requesting, m0 is granted first.

Source files
------------

// File: rtl/mpsoc_spram_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA single-port RAM arbiter.
package mpsoc_spram_arbiter_pkg;

    typedef logic master_t;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } arb_state_t;

    localparam int              BE_W         = 2;
    localparam logic [BE_W-1:0] WEN_READ     = 2'b00;
    localparam logic [BE_W-1:0] RAM_WEN_IDLE = 2'b11;

endpackage

// File: rtl/mpsoc_spram_arbiter_rr.sv
// Two-master round-robin grant with a bounded burst hold on the last owner.
module mpsoc_spram_arbiter_rr
    import mpsoc_spram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       mclk,
    input  logic       puc_rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output master_t    gsel
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    master_t       owner;
    master_t       owner_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    arb_state_t    state;
    logic          hold;

    assign state = (cnt == '0) ? ST_IDLE : ST_HOLD;
    assign hold  = (state == ST_HOLD) && (cnt < CNT_MAX);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            owner <= 1'b1;
            cnt   <= '0;
        end else begin
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        gnt       = '0;
        gsel      = owner;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        if (!puc_rst) begin
            case (req)
                2'b01:   gsel = 1'b0;
                2'b10:   gsel = 1'b1;
                2'b11:   gsel = hold ? owner : ~owner;
                default: gsel = owner;
            endcase
            if (req != 2'b00) begin
                gnt = gsel ? 2'b10 : 2'b01;
                // Saturate so a lone requester keeps the grant without wrapping.
                if (gsel == owner && state == ST_HOLD) begin
                    cnt_nxt = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CW'(1);
                end else begin
                    owner_nxt = gsel;
                    cnt_nxt   = CW'(1);
                end
            end else begin
                cnt_nxt = '0;
            end
        end
    end

endmodule

// File: rtl/mpsoc_spram_arbiter.sv
// Shares one single-port RAM between CPU (master 0) and DMA (master 1);
// muxes the granted access onto the RAM and steers read data back.
module mpsoc_spram_arbiter
    import mpsoc_spram_arbiter_pkg::*;
#(
    parameter int AW        = 6,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic            mclk,
    input  logic            puc_rst,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_din,
    input  logic [BE_W-1:0] m0_wen,
    output logic            m0_gnt,
    output logic [DW-1:0]   m0_dout,
    output logic            m0_rvalid,
    input  logic            m1_req,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_din,
    input  logic [BE_W-1:0] m1_wen,
    output logic            m1_gnt,
    output logic [DW-1:0]   m1_dout,
    output logic            m1_rvalid,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    output logic            ram_cen,
    output logic [BE_W-1:0] ram_wen,
    input  logic [DW-1:0]   ram_dout
);

    logic [1:0][AW-1:0]   addr_v;
    logic [1:0][DW-1:0]   din_v;
    logic [1:0][BE_W-1:0] wen_v;
    logic [1:0]           gnt;
    master_t              gsel;
    logic                 granted;
    logic                 rd_go;
    logic                 rd_pend;
    master_t              rd_tag;

    assign addr_v = {m1_addr, m0_addr};
    assign din_v  = {m1_din, m0_din};
    assign wen_v  = {m1_wen, m0_wen};

    mpsoc_spram_arbiter_rr #(
        .MAX_BURST (MAX_BURST)
    ) u_rr (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .req     ({m1_req, m0_req}),
        .gnt     (gnt),
        .gsel    (gsel)
    );

    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];
    assign granted = |gnt;

    assign ram_cen  = ~granted;
    assign ram_addr = granted ? addr_v[gsel] : '0;
    assign ram_din  = granted ? din_v[gsel] : '0;
    assign ram_wen  = granted ? ~wen_v[gsel] : RAM_WEN_IDLE;
    assign rd_go    = granted && (wen_v[gsel] == WEN_READ);

    // Tag tracks which master owns the word the RAM returns next cycle.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            rd_pend <= rd_go;
            if (rd_go) rd_tag <= gsel;
        end
    end

    assign m0_rvalid = rd_pend && (rd_tag == 1'b0);
    assign m1_rvalid = rd_pend && (rd_tag == 1'b1);
    assign m0_dout   = m0_rvalid ? ram_dout : '0;
    assign m1_dout   = m1_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_mpsoc_spram_arbiter.sv
// Directed bench for mpsoc_spram_arbiter with a behavioural byte-write RAM.
module tb_mpsoc_spram_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          mclk;
    logic          puc_rst;
    logic          m0_req, m1_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_din, m1_din;
    logic [1:0]    m0_wen, m1_wen;
    logic          m0_gnt, m1_gnt;
    logic [DW-1:0] m0_dout, m1_dout;
    logic          m0_rvalid, m1_rvalid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_cen;
    logic [1:0]    ram_wen;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [64];
    int            n_chk;
    int            n_err;

    mpsoc_spram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_din    (m0_din),
        .m0_wen    (m0_wen),
        .m0_gnt    (m0_gnt),
        .m0_dout   (m0_dout),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_din    (m1_din),
        .m1_wen    (m1_wen),
        .m1_gnt    (m1_gnt),
        .m1_dout   (m1_dout),
        .m1_rvalid (m1_rvalid),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_cen   (ram_cen),
        .ram_wen   (ram_wen),
        .ram_dout  (ram_dout)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // RAM contents reload while reset is high: word i holds 16'h1000+i, word 3 is zero.
    always @(posedge mclk) begin
        if (puc_rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
            mem[3] <= 16'h0000;
        end else if (!ram_cen) begin
            if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            if (ram_wen == 2'b11) ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk_idle_ram(input string tag);
        chk({tag, "_cen"},  32'(ram_cen),  32'h1);
        chk({tag, "_wen"},  32'(ram_wen),  32'h3);
        chk({tag, "_addr"}, 32'(ram_addr), 32'h0);
        chk({tag, "_din"},  32'(ram_din),  32'h0);
    endtask

    int          exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int          prev_g;
    int          w0, w1, max_w0, max_w1;

    initial begin
        n_chk = 0; n_err = 0;
        puc_rst = 1'b1;
        m0_req = 0; m0_addr = '0; m0_din = '0; m0_wen = '0;
        m1_req = 0; m1_addr = '0; m1_din = '0; m1_wen = '0;

        // Reset state
        cyc(); cyc(); #3;
        chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rst_dout", {m1_dout, m0_dout}, 32'h0);
        chk_idle_ram("rst");
        cyc(); puc_rst = 1'b0; #3;
        chk("idle_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk_idle_ram("idle");

        // Single read by m0 from address 5
        cyc(); m0_req = 1; m0_addr = 6'd5; m0_wen = 2'b00; #3;
        chk("t1_gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("t1_cen", 32'(ram_cen), 32'h0);
        chk("t1_addr", 32'(ram_addr), 32'd5);
        chk("t1_ramwen", 32'(ram_wen), 32'h3);
        cyc(); m0_req = 0; #3;
        chk("t1_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("t1_dout", 32'(m0_dout), 32'h1005);

        // Contention from the first cycle after reset
        puc_rst = 1'b1;
        cyc(); puc_rst = 1'b0;
        m0_req = 1; m0_addr = 6'd1; m1_req = 1; m1_addr = 6'd2;
        m0_wen = 2'b00; m1_wen = 2'b00;
        prev_g = -1; w0 = 0; w1 = 0; max_w0 = 0; max_w1 = 0;
        for (int i = 0; i < 9; i++) begin
            #3;
            chk($sformatf("t2_gnt%0d", i), {m1_gnt, m0_gnt}, exp_seq[i] == 1 ? 2'b10 : 2'b01);
            if (prev_g == 0) begin
                chk($sformatf("t2_rv%0d", i), {m1_rvalid, m0_rvalid}, 2'b01);
                chk($sformatf("t2_d%0d", i), 32'(m0_dout), 32'h1001);
            end else if (prev_g == 1) begin
                chk($sformatf("t2_rv%0d", i), {m1_rvalid, m0_rvalid}, 2'b10);
                chk($sformatf("t2_d%0d", i), 32'(m1_dout), 32'h1002);
            end
            w0 = m0_gnt ? 0 : w0 + 1;
            w1 = m1_gnt ? 0 : w1 + 1;
            if (w0 > max_w0) max_w0 = w0;
            if (w1 > max_w1) max_w1 = w1;
            prev_g = exp_seq[i];
            cyc();
        end
        chk("t2_wait0", 32'(max_w0), 32'd4);
        chk("t2_wait1", 32'(max_w1), 32'd4);
        m0_req = 0; m1_req = 0; #3;
        chk("t2_last_rv", {m1_rvalid, m0_rvalid}, 2'b01);

        // m1 partial write of the upper byte, then m0 reads it back
        cyc(); m1_req = 1; m1_addr = 6'd3; m1_din = 16'hAB12; m1_wen = 2'b10; #3;
        chk("t3_gnt", {m1_gnt, m0_gnt}, 2'b10);
        chk("t3_ramwen", 32'(ram_wen), 32'h1);
        chk("t3_din", 32'(ram_din), 32'hAB12);
        chk("t3_addr", 32'(ram_addr), 32'd3);
        cyc(); m1_req = 0; m1_wen = 2'b00; m0_req = 1; m0_addr = 6'd3; #3;
        chk("t3_m1rv_a", 32'(m1_rvalid), 32'h0);
        chk("t3_rgnt", {m1_gnt, m0_gnt}, 2'b01);
        cyc(); m0_req = 0; #3;
        chk("t3_rv", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("t3_dout", 32'(m0_dout), 32'hAB00);

        // m1 alone for ten cycles, then m0 joins
        cyc(); m1_req = 1; m1_addr = 6'd7;
        for (int i = 0; i < 10; i++) begin
            #3;
            chk($sformatf("t4_gnt%0d", i), {m1_gnt, m0_gnt}, 2'b10);
            cyc();
        end
        m0_req = 1; m0_addr = 6'd9; #3;
        chk("t4_join", {m1_gnt, m0_gnt}, 2'b01);
        chk("t4_rv", {m1_rvalid, m0_rvalid}, 2'b10);
        chk("t4_dout", 32'(m1_dout), 32'h1007);
        cyc(); m0_req = 0; m1_req = 0; #3;
        chk("t4_m0rv", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("t4_m0d", 32'(m0_dout), 32'h1009);

        // m1 read granted while m0 denied; data steered only to m1
        cyc(); m0_req = 1; m1_req = 1; #3;
        chk("t5_gnt", {m1_gnt, m0_gnt}, 2'b10);
        cyc(); m1_req = 0; #3;
        chk("t5_rv", {m1_rvalid, m0_rvalid}, 2'b10);
        chk("t5_m1d", 32'(m1_dout), 32'h1007);
        chk("t5_m0d", 32'(m0_dout), 32'h0);
        chk("t5_m0gnt", {m1_gnt, m0_gnt}, 2'b01);

        // Reset in the cycle after m0's read grant
        cyc(); puc_rst = 1'b1; m1_req = 1; #3;
        chk("t6_rv", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("t6_dout", 32'(m0_dout), 32'h0);
        chk("t6_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk_idle_ram("t6");
        cyc(); #3;
        chk("t6_gnt_b", {m1_gnt, m0_gnt}, 2'b00);
        cyc(); puc_rst = 1'b0; #3;
        chk("t6_first", {m1_gnt, m0_gnt}, 2'b01);
        chk("t6_addr", 32'(ram_addr), 32'd9);
        cyc(); m0_req = 0; m1_req = 0; #3;
        chk("t6_rv_after", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("t6_d_after", 32'(m0_dout), 32'h1009);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
